// File: rtl/pwm_capture_if.sv
// pwm_capture_if -- groups the measurement request, the PWM line and the
// measurement results of pwm_capture into one bundle.
//   start      : request one measurement (master -> slave)
//   pwm_in     : PWM line, asynchronous to the capture clock (master -> slave)
//   duty_cycle : measured high time in clk cycles, saturated at 15 (slave -> master)
//   ready      : one-cycle pulse, duty_cycle/err updated in this cycle (slave -> master)
//   busy       : a measurement is in progress (slave -> master)
//   err        : last measurement invalid (slave -> master)
interface pwm_capture_if;
  logic       start;
  logic       pwm_in;
  logic [3:0] duty_cycle;
  logic       ready;
  logic       busy;
  logic       err;

  modport master (
    output start,
    output pwm_in,
    input  duty_cycle,
    input  ready,
    input  busy,
    input  err
  );

  modport slave (
    input  start,
    input  pwm_in,
    output duty_cycle,
    output ready,
    output busy,
    output err
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture -- measures the high time and the period of one PWM cycle on an
// asynchronous line and reports the high time (saturated at 15) plus an error
// flag when the period differs from PERIOD or the line is stuck high.
//   clk : capture clock, all state on the rising edge
//   rst : asynchronous, active-low reset
//   bus : pwm_capture_if.slave (start, pwm_in in; duty_cycle, ready, busy, err out)
// Parameters: PERIOD (2..255) expected period in clk cycles,
//             TIMEOUT (1..255) cycles without the awaited edge before aborting.
module pwm_capture #(
  parameter int unsigned PERIOD  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] PERIOD_C  = 8'(PERIOD);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  function automatic logic [3:0] sat_duty(input logic [7:0] v);
    return (v > 8'd15) ? 4'd15 : v[3:0];
  endfunction

  state_t     state_r, state_next;
  logic       sync1_r, sync2_r, pwm_d_r;
  logic       arm_first_r;
  logic [7:0] high_cnt_r, per_cnt_r, tmo_cnt_r;
  logic [7:0] high_next_s, per_next_s, tmo_inc_s;
  logic       rise_s, fall_s, timeout_s;
  logic [3:0] done_duty_s, duty_r;
  logic       done_err_s, err_r, ready_r, busy_r;

  assign rise_s    = sync2_r & ~pwm_d_r;
  assign fall_s    = ~sync2_r & pwm_d_r;
  assign tmo_inc_s = sat_inc(tmo_cnt_r);
  assign timeout_s = (tmo_inc_s >= TIMEOUT_C);

  assign bus.duty_cycle = duty_r;
  assign bus.ready      = ready_r;
  assign bus.busy       = busy_r;
  assign bus.err        = err_r;

  // Two-flop synchronizer plus edge-detect register on the PWM line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      pwm_d_r <= 1'b0;
    end else begin
      sync1_r <= bus.pwm_in;
      sync2_r <= sync1_r;
      pwm_d_r <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next state, next counter values and the result latched on entry to DONE.
  always_comb begin
    state_next  = state_r;
    high_next_s = high_cnt_r;
    per_next_s  = per_cnt_r;
    done_duty_s = duty_r;
    done_err_s  = err_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next  = ARM;
          high_next_s = 8'd0;
          per_next_s  = 8'd0;
        end else begin
          state_next = IDLE;
        end
      end
      ARM: begin
        // A rise seen in the first ARM cycle was already under way when the
        // request arrived, so only a later rise opens the measurement.
        if (rise_s && !arm_first_r) begin
          state_next  = HIGH;
          high_next_s = 8'd1;
          per_next_s  = 8'd1;
        end else if (timeout_s) begin
          state_next  = DONE;
          done_duty_s = sync2_r ? 4'd15 : 4'd0;
          done_err_s  = sync2_r;
        end else begin
          state_next = ARM;
        end
      end
      HIGH: begin
        // The awaited edge takes priority over an expiring timeout.
        if (fall_s) begin
          state_next = LOW;
          per_next_s = sat_inc(per_cnt_r);
        end else begin
          high_next_s = sat_inc(high_cnt_r);
          per_next_s  = sat_inc(per_cnt_r);
          if (timeout_s) begin
            state_next  = DONE;
            done_duty_s = sync2_r ? 4'd15 : 4'd0;
            done_err_s  = sync2_r;
          end else begin
            state_next = HIGH;
          end
        end
      end
      LOW: begin
        if (rise_s) begin
          state_next  = DONE;
          done_duty_s = sat_duty(high_cnt_r);
          done_err_s  = (per_cnt_r != PERIOD_C);
        end else begin
          per_next_s = sat_inc(per_cnt_r);
          if (timeout_s) begin
            state_next  = DONE;
            done_duty_s = sync2_r ? 4'd15 : 4'd0;
            done_err_s  = sync2_r;
          end else begin
            state_next = LOW;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counters, timeout tracking and registered outputs aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_cnt_r  <= 8'd0;
      per_cnt_r   <= 8'd0;
      tmo_cnt_r   <= 8'd0;
      arm_first_r <= 1'b0;
      duty_r      <= 4'd0;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      high_cnt_r  <= high_next_s;
      per_cnt_r   <= per_next_s;
      arm_first_r <= (state_r == IDLE) && (state_next == ARM);
      if ((state_next != state_r) || rise_s || fall_s) begin
        tmo_cnt_r <= 8'd0;
      end else if ((state_r == ARM) || (state_r == HIGH) || (state_r == LOW)) begin
        tmo_cnt_r <= tmo_inc_s;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      ready_r <= (state_next == DONE);
      busy_r  <= (state_next != IDLE);
      if (state_next == DONE) begin
        duty_r <= done_duty_s;
        err_r  <= done_err_s;
      end else begin
        duty_r <= duty_r;
        err_r  <= err_r;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter PERIOD, default 16: expected PWM period in clk cycles; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 64: clk cycles without the awaited edge before a measurement aborts; legal range 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one measurement; sampled only in IDLE.
REQ-006 pwm_in  input  1  PWM line, asynchronous to clk.
REQ-007 duty_cycle  output  4  measured high-time in clk cycles, saturated at 15.
REQ-008 ready  output  1  one-cycle pulse; duty_cycle/err valid and updated in this cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 err  output  1  last measurement invalid (period mismatch or stuck-high).

Function
REQ-011 pwm_in SHALL pass a 2-flop synchronizer; a third register gives pwm_d; rise = sync & ~pwm_d, fall = ~sync & pwm_d.
REQ-012 FSM states SHALL be IDLE, ARM, HIGH, LOW, DONE.
REQ-013 IDLE: start=1 -> ARM, clear high_cnt, per_cnt, tmo_cnt; start=0 -> stay.
REQ-014 ARM: rise -> HIGH with high_cnt=1, per_cnt=1; a rise already in progress at entry SHALL NOT count (measurement starts at a fresh rising edge).
REQ-015 HIGH: each cycle without fall increments high_cnt and per_cnt; fall -> LOW, per_cnt increments.
REQ-016 LOW: each cycle without rise increments per_cnt; rise -> DONE.
REQ-017 high_cnt, per_cnt, tmo_cnt SHALL be 8 bits, saturating at 255 (no wrap).
REQ-018 tmo_cnt SHALL clear on every state change and on every rise/fall, otherwise increment in ARM, HIGH, LOW; tmo_cnt reaching TIMEOUT -> DONE via timeout path.
REQ-019 Normal DONE: duty_cycle = min(high_cnt,15); err = (per_cnt != PERIOD).
REQ-020 Timeout DONE: synchronized line low -> duty_cycle=0, err=0; line high -> duty_cycle=15, err=1.
REQ-021 DONE lasts exactly one cycle with ready=1, then -> IDLE.
REQ-022 duty_cycle and err SHALL hold their values between DONE cycles.
REQ-023 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-024 Simultaneous timeout and awaited edge in the same cycle: the edge wins.
REQ-025 Latency: ready SHALL assert 3 cycles (synchronizer + edge register) after the pwm_in rising edge that closes the period, ±1 cycle for asynchronous sampling.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, clear all counters and synchronizer flops, duty_cycle=0, ready=0, busy=0, err=0.
REQ-027 Reset asserted mid-measurement SHALL abort it; no ready pulse is produced for the aborted measurement.
REQ-028 After rst release, the first measurement SHALL start only on a new start pulse.

Verification
REQ-029 PERIOD=16, pwm_in 5 high / 11 low repeating, pulse start -> one ready pulse, duty_cycle=5, err=0, busy low the cycle after.
REQ-030 pwm_in held 0, pulse start -> ready exactly TIMEOUT=64 cycles after entering ARM, duty_cycle=0, err=0.
REQ-031 pwm_in held 1, pulse start -> ready after 64 cycles, duty_cycle=15, err=1.
REQ-032 pwm_in 5 high / 15 low (period 20), start -> duty_cycle=5, err=1.
REQ-033 Measurement in HIGH, rst pulsed low 1 cycle -> outputs all 0 asynchronously, no ready; new start after release measures correctly.
REQ-034 start re-pulsed while busy -> exactly one ready pulse; 15 high / 1 low input -> duty_cycle=15, err=0.
